rv_multicycle_ctrl: RTL and testbench
=====================================

# rv_multicycle_ctrl

Multicycle sequencer for the RV32I core: a Moore/Mealy FSM that steps one shared instruction/data memory, the register file and the ALU through fetch, decode, execute, memory and writeback. It replaces the single-cycle opcode decoder in the multicycle datapath. It handles R-type, I-type ALU, `lw`, `sw` and `beq`, and stalls on a memory ready handshake. It also keeps a retired-instruction counter.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `OPcode`, input, 7: `IR[6:0]`, taken from the instruction register.
- `Zero`, input, 1: ALU zero flag.
- `mem_ready`, input, 1: memory completes the current access this cycle.
- `mem_req`, output, 1: memory access request.
- `MemRead`, output, 1: read strobe.
- `MemWrite`, output, 1: write strobe.
- `IorD`, output, 1: address select; 0 selects PC, 1 selects ALUOut.
- `IRWrite`, output, 1: load the instruction register.
- `PCWrite`, output, 1: load the PC.
- `PCSource`, output, 1: PC input select; 0 selects ALU result, 1 selects ALUOut.
- `ALUSrcA`, output, 1: ALU A select; 0 selects PC, 1 selects rs1.
- `ALUSrcB`, output, 2: ALU B select; 00 selects rs2, 01 selects constant 4, 10 selects imm, 11 selects branch offset.
- `ALUOp`, output, 2: 00 forced add, 01 load/store address add, 10 R-type, 11 I-type.
- `BranchCmp`, output, 1: forces a subtract in ALU control.
- `RegWrite`, output, 1: register file write enable.
- `MemtoReg`, output, 1: writeback select; 1 selects MDR.
- `illegal_op`, output, 1: one-cycle pulse on an unsupported opcode.
- `instret`, output, `CNT_W`: count of retired instructions.

## Operation
- States:
  - IDLE leaves unconditionally to FETCH on the first edge after reset deasserts.
  - FETCH waits for `mem_ready`, then goes to DECODE.
  - DECODE branches on opcode:
    - `0110011` → EXEC_R
    - `0010011` → EXEC_I
    - `0000011` or `0100011` → ADDR
    - `1100011` → BRANCH
    - anything else → FETCH with `illegal_op`=1.
  - EXEC_R and EXEC_I → WB_ALU.
  - ADDR → MEM_RD for `lw`, MEM_WR for `sw`.
  - MEM_RD waits for `mem_ready`, then goes to WB_MEM.
  - MEM_WR waits for `mem_ready`, then goes to FETCH.
  - WB_ALU, WB_MEM and BRANCH → FETCH.
- Outputs not listed for a state are 0.
  - IDLE: all outputs 0.
  - FETCH: `mem_req`=`MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00. `IRWrite` and `PCWrite` are combinational on `mem_ready`: both equal `mem_ready`.
  - DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00, so the branch target is latched into ALUOut.
  - EXEC_R: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10.
  - EXEC_I: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=11.
  - ADDR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=01.
  - MEM_RD: `mem_req`=`MemRead`=1, `IorD`=1.
  - MEM_WR: `mem_req`=`MemWrite`=1, `IorD`=1.
  - WB_ALU: `RegWrite`=1, `MemtoReg`=0.
  - WB_MEM: `RegWrite`=1, `MemtoReg`=1.
  - BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `BranchCmp`=1, `PCSource`=1, `PCWrite`=`Zero`.
- `instret` increments by 1 on every edge that leaves WB_ALU, WB_MEM, MEM_WR (with `mem_ready`) or BRANCH into FETCH.
  - It wraps modulo 2^`CNT_W`.
  - Illegal opcodes do not increment it.

## Timing
- Reset: the state goes to IDLE, all outputs go to 0 and `instret` clears to 0, all immediately and independently of `clk`.
  - A pending memory access is abandoned; `mem_req` falls asynchronously.
- Instruction latencies with zero-wait memory (`mem_ready`=1 on the first request cycle), FETCH to next FETCH:
  - R-type and I-type: 4 cycles.
  - `lw`: 5 cycles.
  - `sw`: 4 cycles.
  - `beq`: 3 cycles.
  - Illegal opcode: 2 cycles.
- Each memory wait cycle adds exactly 1 cycle.
- Handshake:
  - `mem_req`, `IorD`, `MemRead` and `MemWrite` stay stable from entry into FETCH, MEM_RD or MEM_WR until the edge at which `mem_ready`=1.
  - `mem_ready` is ignored in every other state.
- `IRWrite`, `PCWrite` (in FETCH) and `PCWrite` (in BRANCH) are Mealy outputs, valid in the same cycle as `mem_ready`/`Zero`.
- `OPcode` is sampled only in DECODE and in ADDR (to tell `lw` from `sw`). It is held stable by the IR, because `IRWrite`=0 outside FETCH.

## Structure
- Package `rv_ctrl_pkg` holds:
  - opcode constants `OP_R`, `OP_I`, `OP_LOAD`, `OP_STORE`, `OP_BRANCH`
  - the state enum
  - ALUOp codes `ALU_ADD`, `ALU_MEM`, `ALU_R`, `ALU_I`
  - ALUSrcB select codes.
- One sub-module, `rv_mc_outdec`: purely combinational; maps (state, `mem_ready`, `Zero`) to the output bundle.
- The top holds the state register, the next-state logic and the `instret` counter.

## Test plan
- Reset held, then released, with `OPcode`=`0110011` and `mem_ready`=1:
  - all outputs are 0 during reset
  - IDLE→FETCH→DECODE→EXEC_R→WB_ALU→FETCH, with `RegWrite`=1 only in WB_ALU
  - `instret`=1.
- `lw` (`0000011`) with `mem_ready` low for 2 cycles in MEM_RD:
  - `mem_req`/`MemRead`/`IorD`=1 held for 3 cycles
  - WB_MEM follows with `MemtoReg`=1
  - total 7 cycles.
- `sw` (`0100011`):
  - MEM_WR with `MemWrite`=1 and `IorD`=1
  - no `RegWrite` at any point
  - returns to FETCH after 4 cycles, `instret` +1.
- `beq` (`1100011`) run twice:
  - with `Zero`=1: `PCWrite`=1, `PCSource`=1 in BRANCH
  - with `Zero`=0: `PCWrite`=0
  - 3 cycles each.
- Opcode `1111111`:
  - `illegal_op` is a 1-cycle pulse in DECODE
  - no `RegWrite`/`MemWrite`
  - `instret` unchanged.
- Reset asserted mid-MEM_RD: `mem_req` drops within the same cycle, the state goes to IDLE and `instret`=0.
- `instret` preloaded to all-ones, then one instruction retires: it wraps to 0.

Source files
------------

// File: rtl/rv_multicycle_ctrl_pkg.sv
// Shared constants and types for the RV32I multicycle sequencer: opcodes,
// FSM states, ALU control codes and the control-output bundle.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_MEM = 2'b01;
    localparam logic [1:0] ALU_R   = 2'b10;
    localparam logic [1:0] ALU_I   = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_BRANCH
    } state_e;

    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       branch_cmp;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;

    function automatic logic op_supported(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle. The datapath side is the
// master (drives opcode, flags, ready); the sequencer is the slave.
interface rv_multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       OPcode;
    logic             Zero;
    logic             mem_ready;
    logic             mem_req;
    logic             MemRead;
    logic             MemWrite;
    logic             IorD;
    logic             IRWrite;
    logic             PCWrite;
    logic             PCSource;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic             BranchCmp;
    logic             RegWrite;
    logic             MemtoReg;
    logic             illegal_op;
    logic [CNT_W-1:0] instret;

    modport master (
        output OPcode, Zero, mem_ready,
        input  mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource,
               ALUSrcA, ALUSrcB, ALUOp, BranchCmp, RegWrite, MemtoReg,
               illegal_op, instret
    );

    modport slave (
        input  OPcode, Zero, mem_ready,
        output mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource,
               ALUSrcA, ALUSrcB, ALUOp, BranchCmp, RegWrite, MemtoReg,
               illegal_op, instret
    );
endinterface

// File: rtl/rv_multicycle_ctrl_outdec.sv
// Combinational output decoder: state plus the two Mealy inputs (mem_ready,
// Zero) to the datapath control bundle.
module rv_mc_outdec
    import rv_ctrl_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    input  logic   zero_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            S_FETCH: begin
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                // Precompute PC + branch offset into ALUOut for a possible beq.
                ctrl_o.alu_src_b = SRCB_BOFF;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_EXEC_R: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_RS2;
                ctrl_o.alu_op    = ALU_R;
            end
            S_EXEC_I: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_I;
            end
            S_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_MEM;
            end
            S_MEM_RD: begin
                ctrl_o.mem_req  = 1'b1;
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_WB_ALU: begin
                ctrl_o.reg_write = 1'b1;
            end
            S_WB_MEM: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a  = 1'b1;
                ctrl_o.alu_src_b  = SRCB_RS2;
                ctrl_o.branch_cmp = 1'b1;
                ctrl_o.pc_source  = 1'b1;
                ctrl_o.pc_write   = zero_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multicycle RV32I sequencer: state register, next-state logic and the
// retired-instruction counter; outputs come from rv_mc_outdec.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    rv_multicycle_ctrl_if.slave bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;
    ctrl_t            ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (bus.OPcode)
                    OP_R:               state_d = S_EXEC_R;
                    OP_I:               state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_ADDR;
                    OP_BRANCH:          state_d = S_BRANCH;
                    default:            state_d = S_FETCH;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_ADDR:   state_d = (bus.OPcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: if (bus.mem_ready) state_d = S_WB_MEM;
            S_MEM_WR: if (bus.mem_ready) state_d = S_FETCH;
            S_WB_ALU, S_WB_MEM, S_BRANCH: state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    // An instruction retires on the edge that completes its last state.
    assign retire = (state_q == S_WB_ALU) || (state_q == S_WB_MEM) ||
                    (state_q == S_BRANCH) ||
                    ((state_q == S_MEM_WR) && bus.mem_ready);

    assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

    rv_mc_outdec u_outdec (
        .state_i     (state_q),
        .mem_ready_i (bus.mem_ready),
        .zero_i      (bus.Zero),
        .ctrl_o      (ctrl)
    );

    assign bus.mem_req    = ctrl.mem_req;
    assign bus.MemRead    = ctrl.mem_read;
    assign bus.MemWrite   = ctrl.mem_write;
    assign bus.IorD       = ctrl.iord;
    assign bus.IRWrite    = ctrl.ir_write;
    assign bus.PCWrite    = ctrl.pc_write;
    assign bus.PCSource   = ctrl.pc_source;
    assign bus.ALUSrcA    = ctrl.alu_src_a;
    assign bus.ALUSrcB    = ctrl.alu_src_b;
    assign bus.ALUOp      = ctrl.alu_op;
    assign bus.BranchCmp  = ctrl.branch_cmp;
    assign bus.RegWrite   = ctrl.reg_write;
    assign bus.MemtoReg   = ctrl.mem_to_reg;
    assign bus.illegal_op = (state_q == S_DECODE) && !op_supported(bus.OPcode);
    assign bus.instret    = instret_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Scoreboard bench for rv_multicycle_ctrl: each scenario queues per-cycle
// stimulus with the expected control vector, then replays and compares.
module tb_rv_multicycle_ctrl;

    localparam int CW = 4;

    localparam logic [6:0] T_R    = 7'b0110011;
    localparam logic [6:0] T_I    = 7'b0010011;
    localparam logic [6:0] T_LW   = 7'b0000011;
    localparam logic [6:0] T_SW   = 7'b0100011;
    localparam logic [6:0] T_BEQ  = 7'b1100011;
    localparam logic [6:0] T_BAD  = 7'b1111111;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    rv_multicycle_ctrl_if #(.CNT_W(CW)) ctrl_bus ();

    rv_multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ctrl_bus)
    );

    typedef struct {
        logic [6:0]  op;
        logic        rdy;
        logic        z;
        logic [15:0] exp;
        string       name;
    } entry_t;

    entry_t          sb_q[$];
    int              n_checks = 0;
    int              n_fail   = 0;
    logic [CW-1:0]   exp_cnt  = '0;

    function automatic logic [15:0] observed();
        return {ctrl_bus.mem_req, ctrl_bus.MemRead, ctrl_bus.MemWrite, ctrl_bus.IorD,
                ctrl_bus.IRWrite, ctrl_bus.PCWrite, ctrl_bus.PCSource, ctrl_bus.ALUSrcA,
                ctrl_bus.ALUSrcB, ctrl_bus.ALUOp, ctrl_bus.BranchCmp, ctrl_bus.RegWrite,
                ctrl_bus.MemtoReg, ctrl_bus.illegal_op};
    endfunction

    function automatic logic [15:0] ctl(input logic mreq, input logic mrd, input logic mwr,
                                        input logic iord, input logic irw, input logic pcw,
                                        input logic pcs, input logic srca, input logic [1:0] srcb,
                                        input logic [1:0] aop, input logic bcmp, input logic rw,
                                        input logic m2r, input logic ill);
        return {mreq, mrd, mwr, iord, irw, pcw, pcs, srca, srcb, aop, bcmp, rw, m2r, ill};
    endfunction

    // Expected control vectors, written out from the state output table.
    function automatic logic [15:0] e_fetch(input logic r);
        return ctl(1, 1, 0, 0, r, r, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] e_decode(input logic ill);
        return ctl(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 0, ill);
    endfunction
    function automatic logic [15:0] e_exec_r();
        return ctl(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] e_exec_i();
        return ctl(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b11, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] e_addr();
        return ctl(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b01, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] e_mem_rd();
        return ctl(1, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] e_mem_wr();
        return ctl(1, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] e_wb_alu();
        return ctl(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0);
    endfunction
    function automatic logic [15:0] e_wb_mem();
        return ctl(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 1, 0);
    endfunction
    function automatic logic [15:0] e_branch(input logic z);
        return ctl(0, 0, 0, 0, 0, z, 1, 1, 2'b00, 2'b00, 1, 0, 0, 0);
    endfunction

    task automatic push(input logic [6:0] op, input logic rdy, input logic z,
                        input logic [15:0] exp, input string name);
        entry_t e;
        e.op = op; e.rdy = rdy; e.z = z; e.exp = exp; e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic run_queue();
        entry_t      e;
        logic [15:0] got;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk);
            ctrl_bus.OPcode    = e.op;
            ctrl_bus.mem_ready = e.rdy;
            ctrl_bus.Zero      = e.z;
            #1;
            got = observed();
            n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: ctrl got %b expected %b", e.name, got, e.exp);
            end
        end
    endtask

    task automatic check_instret(input string name);
        @(posedge clk);
        #1;
        n_checks++;
        if (ctrl_bus.instret !== exp_cnt) begin
            n_fail++;
            $display("FAIL %s_instret: got %0d expected %0d", name, ctrl_bus.instret, exp_cnt);
        end
        $display("txn %s done, instret=%0d", name, ctrl_bus.instret);
    endtask

    task automatic check_idle(input string name);
        n_checks++;
        if (observed() !== 16'h0) begin
            n_fail++;
            $display("FAIL %s_outputs: got %b expected 0", name, observed());
        end
        n_checks++;
        if (ctrl_bus.instret !== '0) begin
            n_fail++;
            $display("FAIL %s_instret: got %0d expected 0", name, ctrl_bus.instret);
        end
    endtask

    task automatic test_reset();
        ctrl_bus.OPcode    = T_R;
        ctrl_bus.mem_ready = 1'b1;
        ctrl_bus.Zero      = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check_idle("reset_held");
        end
        reset = 1'b0;
        #1;
        check_idle("idle_after_release");
        exp_cnt = '0;
        push(T_R, 1, 0, e_fetch(1), "r_fetch");
        push(T_R, 1, 0, e_decode(0), "r_decode");
        push(T_R, 1, 0, e_exec_r(), "r_exec");
        push(T_R, 1, 0, e_wb_alu(), "r_wb");
        run_queue();
        exp_cnt++;
        check_instret("rtype");
    endtask

    task automatic test_itype_fetch_wait();
        push(T_I, 0, 1, e_fetch(0), "i_fetch_wait");
        push(T_I, 1, 1, e_fetch(1), "i_fetch");
        push(T_I, 0, 1, e_decode(0), "i_decode");
        push(T_I, 1, 1, e_exec_i(), "i_exec");
        push(T_I, 0, 1, e_wb_alu(), "i_wb");
        run_queue();
        exp_cnt++;
        check_instret("itype");
    endtask

    task automatic test_lw_wait();
        push(T_LW, 1, 0, e_fetch(1), "lw_fetch");
        push(T_LW, 1, 0, e_decode(0), "lw_decode");
        push(T_LW, 1, 0, e_addr(), "lw_addr");
        push(T_LW, 0, 0, e_mem_rd(), "lw_mem_wait1");
        push(T_LW, 0, 0, e_mem_rd(), "lw_mem_wait2");
        push(T_LW, 1, 0, e_mem_rd(), "lw_mem_done");
        push(T_LW, 0, 0, e_wb_mem(), "lw_wb");
        run_queue();
        exp_cnt++;
        check_instret("lw");
    endtask

    task automatic test_sw();
        push(T_SW, 1, 0, e_fetch(1), "sw_fetch");
        push(T_SW, 1, 0, e_decode(0), "sw_decode");
        push(T_SW, 1, 0, e_addr(), "sw_addr");
        push(T_SW, 1, 0, e_mem_wr(), "sw_mem");
        run_queue();
        exp_cnt++;
        check_instret("sw");
    endtask

    task automatic test_beq();
        for (int k = 0; k < 2; k++) begin
            logic z;
            z = (k == 0);
            push(T_BEQ, 1, z, e_fetch(1), "beq_fetch");
            push(T_BEQ, 1, z, e_decode(0), "beq_decode");
            push(T_BEQ, 1, z, e_branch(z), z ? "beq_taken" : "beq_not_taken");
            run_queue();
            exp_cnt++;
            check_instret(z ? "beq_z1" : "beq_z0");
        end
    endtask

    task automatic test_illegal();
        push(T_BAD, 1, 0, e_fetch(1), "ill_fetch");
        push(T_BAD, 1, 0, e_decode(1), "ill_decode");
        run_queue();
        check_instret("illegal");
        // Back in FETCH: the pulse must be gone and a legal op must still run.
        push(T_BEQ, 0, 0, e_fetch(0), "post_ill_fetch");
        push(T_BEQ, 1, 0, e_fetch(1), "post_ill_fetch_rdy");
        push(T_BEQ, 1, 0, e_decode(0), "post_ill_decode");
        push(T_BEQ, 1, 0, e_branch(0), "post_ill_branch");
        run_queue();
        exp_cnt++;
        check_instret("post_illegal_beq");
    endtask

    task automatic test_reset_mid_mem();
        push(T_LW, 1, 0, e_fetch(1), "rst_fetch");
        push(T_LW, 1, 0, e_decode(0), "rst_decode");
        push(T_LW, 1, 0, e_addr(), "rst_addr");
        push(T_LW, 0, 0, e_mem_rd(), "rst_mem_pending");
        run_queue();
        reset = 1'b1;
        #1;
        exp_cnt = '0;
        check_idle("reset_mid_mem");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_idle("reset_mid_mem_idle");
        $display("txn reset_mid_mem done, instret=%0d", ctrl_bus.instret);
    endtask

    task automatic test_wrap();
        for (int n = 0; n < (1 << CW); n++) begin
            push(T_BEQ, 1, 0, e_fetch(1), "wrap_fetch");
            push(T_BEQ, 1, 0, e_decode(0), "wrap_decode");
            push(T_BEQ, 1, 0, e_branch(0), "wrap_branch");
            run_queue();
            exp_cnt++;
            check_instret((n == (1 << CW) - 1) ? "wrap_to_zero" : "wrap_count");
        end
    endtask

    initial begin
        test_reset();
        test_itype_fetch_wait();
        test_lw_wait();
        test_sw();
        test_beq();
        test_illegal();
        test_reset_mid_mem();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
